edge_event_arbiter: RTL and testbench

//   Turns N level inputs into single-cycle rising-edge events and queues one

---
 rtl/edge_event_arbiter.sv | 108 ++++++++++
 tb/tb_edge_event_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Rising-edge event queue for N level inputs with one pending flag per channel,
// granted round-robin to a single consumer over a valid/ready handshake.
module edge_event_arbiter #(
  parameter int N    = 2,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    entrada,
  input  logic            evt_ready,
  input  logic            clr_overflow,
  output logic            evt_valid,
  output logic [IDXW-1:0] evt_idx,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overflow
);

  logic [N-1:0]    prev_q, prev_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    overflow_q, overflow_d;
  logic            evt_valid_q, evt_valid_d;
  logic [IDXW-1:0] evt_idx_q, evt_idx_d;
  logic [IDXW-1:0] last_grant_q, last_grant_d;

  logic [N-1:0]    rise_s;
  logic [N-1:0]    gnt_onehot_s;
  logic [N-1:0]    ovf_set_s;
  logic            stage_free_s;
  logic            gnt_found_s;
  logic            hit_s;
  logic [IDXW-1:0] gnt_idx_s;

  // Edge detect, round-robin search over the pre-edge pending set, queue update.
  always_comb begin
    rise_s       = entrada & ~prev_q;
    stage_free_s = !evt_valid_q || evt_ready;
    gnt_found_s  = 1'b0;
    gnt_idx_s    = '0;
    hit_s        = 1'b0;
    gnt_onehot_s = '0;
    ovf_set_s    = '0;
    pending_d    = pending_q;
    prev_d       = entrada;

    // Candidate order is last_grant+1, +2, ... wrapping; first pending hit wins.
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        hit_s       = stage_free_s && !gnt_found_s && pending_q[i] &&
                      (((int'(last_grant_q) + k) % N) == i);
        gnt_idx_s   = hit_s ? IDXW'(i) : gnt_idx_s;
        gnt_found_s = gnt_found_s | hit_s;
      end
    end

    // A rise on a channel being granted this edge refills it instead of overflowing.
    for (int i = 0; i < N; i++) begin
      gnt_onehot_s[i] = gnt_found_s && (gnt_idx_s == IDXW'(i));
      ovf_set_s[i]    = rise_s[i] & pending_q[i] & ~gnt_onehot_s[i];
      pending_d[i]    = (pending_q[i] & ~gnt_onehot_s[i]) | rise_s[i];
    end

    overflow_d = (clr_overflow ? {N{1'b0}} : overflow_q) | ovf_set_s;
  end

  // Output stage: load a new grant when free, otherwise hold the offered event.
  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_idx_d    = evt_idx_q;
    last_grant_d = last_grant_q;
    if (stage_free_s) begin
      evt_valid_d = gnt_found_s;
      if (gnt_found_s) begin
        evt_idx_d    = gnt_idx_s;
        last_grant_d = gnt_idx_s;
      end else begin
        evt_idx_d    = evt_idx_q;
        last_grant_d = last_grant_q;
      end
    end else begin
      evt_valid_d = evt_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q       <= '0;
      pending_q    <= '0;
      overflow_q   <= '0;
      evt_valid_q  <= 1'b0;
      evt_idx_q    <= '0;
      last_grant_q <= IDXW'(N - 1);
    end else begin
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      evt_valid_q  <= evt_valid_d;
      evt_idx_q    <= evt_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_idx   = evt_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against an event-level reference model.
module tb_edge_event_arbiter;
  localparam int N    = 2;
  localparam int IDXW = $clog2(N);

  logic            clk;
  logic            rst;
  logic [N-1:0]    entrada;
  logic            evt_ready;
  logic            clr_overflow;
  logic            evt_valid;
  logic [IDXW-1:0] evt_idx;
  logic [N-1:0]    pending;
  logic [N-1:0]    overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit         m_valid;
  int         m_idx;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_ovf;
  bit [N-1:0] m_prev;
  int         m_last;

  edge_event_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .entrada(entrada), .evt_ready(evt_ready),
    .clr_overflow(clr_overflow), .evt_valid(evt_valid), .evt_idx(evt_idx),
    .pending(pending), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    int g;
    bit free;
    bit [N-1:0] n_pend;
    bit [N-1:0] n_ovf;
    if (!rst) begin
      m_valid = 1'b0; m_idx = 0; m_pend = '0; m_ovf = '0; m_prev = '0; m_last = N - 1;
    end else begin
      g = -1;
      free = !m_valid || evt_ready;
      if (free)
        for (int k = 1; k <= N; k++)
          if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
      n_ovf  = clr_overflow ? '0 : m_ovf;
      n_pend = m_pend;
      if (g >= 0) n_pend[g] = 1'b0;
      for (int i = 0; i < N; i++)
        if (entrada[i] && !m_prev[i]) begin
          if (m_pend[i] && i != g) n_ovf[i] = 1'b1;
          n_pend[i] = 1'b1;
        end
      if (free) begin
        m_valid = (g >= 0);
        if (g >= 0) begin m_idx = g; m_last = g; end
      end
      m_pend = n_pend;
      m_ovf  = n_ovf;
      m_prev = entrada;
    end
  endtask

  // One clock: model consumes the pre-edge inputs, outputs settle by #1.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; entrada = 2'b11; evt_ready = 1'b0; clr_overflow = 1'b0;
    cyc(); cyc();
    checks++;
    if ({evt_valid, evt_idx, pending, overflow} !== {1'b0, 1'b0, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: valid=%0b idx=%0d pend=%b ovf=%b, want all zero", evt_valid, evt_idx, pending, overflow);
    end
    rst = 1'b1; evt_ready = 1'b1;
    cyc();
    checks++;
    if (pending !== 2'b11 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_pend: pend=%b valid=%0b, want pend=11 valid=0", pending, evt_valid);
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 1'b0 || pending !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_g0: valid=%0b idx=%0d pend=%b, want 1/0/10", evt_valid, evt_idx, pending);
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 1'b1 || pending !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_g1: valid=%0b idx=%0d pend=%b, want 1/1/00", evt_valid, evt_idx, pending);
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: valid=%0b, want 0", evt_valid);
    end
  endtask

  task automatic test_single_edge();
    int seen;
    evt_ready = 1'b1; entrada = 2'b00;
    cyc(); cyc();
    entrada = 2'b10;
    cyc();
    checks++;
    if (pending !== 2'b10 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: pend=%b valid=%0b, want 10/0", pending, evt_valid);
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: valid=%0b idx=%0d, want 1/1", evt_valid, evt_idx);
    end
    seen = 0;
    repeat (5) begin
      cyc();
      if (evt_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL single_no_repeat: extra events=%0d, want 0", seen);
    end
  endtask

  task automatic test_simultaneous();
    repeat (2) begin
      evt_ready = 1'b1; entrada = 2'b00;
      cyc();
      entrada = 2'b11;
      cyc(); cyc();
      checks++;
      if (evt_valid !== 1'b1 || evt_idx !== 1'b0) begin
        errors++;
        $display("FAIL simul_first: valid=%0b idx=%0d, want 1/0", evt_valid, evt_idx);
      end
      cyc();
      checks++;
      if (evt_valid !== 1'b1 || evt_idx !== 1'b1 || pending !== 2'b00) begin
        errors++;
        $display("FAIL simul_second: valid=%0b idx=%0d pend=%b, want 1/1/00", evt_valid, evt_idx, pending);
      end
      cyc();
    end
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0; entrada = 2'b00;
    cyc();
    entrada = 2'b01;
    cyc(); cyc();
    entrada = 2'b11; cyc();
    entrada = 2'b01; cyc();
    entrada = 2'b11; cyc();
    checks++;
    if (overflow !== 2'b10 || pending !== 2'b10 || evt_valid !== 1'b1 || evt_idx !== 1'b0) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b pend=%b valid=%0b idx=%0d, want 10/10/1/0", overflow, pending, evt_valid, evt_idx);
    end
    clr_overflow = 1'b1; cyc(); clr_overflow = 1'b0;
    checks++;
    if (overflow !== 2'b00 || pending !== 2'b10 || evt_idx !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b pend=%b idx=%0d, want 00/10/0", overflow, pending, evt_idx);
    end
    evt_ready = 1'b1; cyc();
    checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 1'b1 || pending !== 2'b00) begin
      errors++;
      $display("FAIL ovf_drain: valid=%0b idx=%0d pend=%b, want 1/1/00", evt_valid, evt_idx, pending);
    end
    cyc();
  endtask

  task automatic test_regrant();
    evt_ready = 1'b0; entrada = 2'b00;
    cyc();
    entrada = 2'b10; cyc(); cyc();
    entrada = 2'b11; cyc();
    entrada = 2'b10; cyc();
    entrada = 2'b11; evt_ready = 1'b1; cyc();
    checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 1'b0 || pending !== 2'b01 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL regrant_same_edge: valid=%0b idx=%0d pend=%b ovf=%b, want 1/0/01/00", evt_valid, evt_idx, pending, overflow);
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 1'b0 || pending !== 2'b00) begin
      errors++;
      $display("FAIL regrant_second: valid=%0b idx=%0d pend=%b, want 1/0/00", evt_valid, evt_idx, pending);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0; entrada = 2'b00;
    cyc();
    entrada = 2'b01; cyc(); cyc();
    entrada = 2'b11; cyc();
    rst = 1'b0; cyc();
    checks++;
    if ({evt_valid, evt_idx, pending, overflow} !== {1'b0, 1'b0, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b idx=%0d pend=%b ovf=%b, want all zero", evt_valid, evt_idx, pending, overflow);
    end
    rst = 1'b1; cyc();
    checks++;
    if (pending !== 2'b11 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_edges: pend=%b valid=%0b, want 11/0", pending, evt_valid);
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_grant: valid=%0b idx=%0d, want 1/0", evt_valid, evt_idx);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      entrada      = N'($urandom);
      evt_ready    = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 99) != 0);
      cyc();
      checks++;
      if (evt_valid !== m_valid || pending !== m_pend || overflow !== m_ovf ||
          (m_valid && evt_idx !== IDXW'(m_idx))) begin
        errors++;
        $display("FAIL random c=%0d: valid=%0b idx=%0d pend=%b ovf=%b, want %0b/%0d/%b/%b",
                 c, evt_valid, evt_idx, pending, overflow, m_valid, m_idx, m_pend, m_ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b0; entrada = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    test_reset();
    test_single_edge();
    test_simultaneous();
    test_overflow();
    test_regrant();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
